// File: rtl/timer_ctrl_pkg.sv
// timer_ctrl_pkg: state encodings and widths shared by the timer control stage
// and the countdown stage. Rev 1.0
`default_nettype none

package timer_ctrl_pkg;

    localparam int SEC_W = 6;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUNNING = 2'd1,
        ST_PAUSED  = 2'd2,
        ST_EXPIRED = 2'd3
    } state_t;

endpackage

`default_nettype wire

// File: rtl/timer_ctrl_btn_conditioner.sv
// btn_conditioner: 2-FF synchroniser, counting debouncer and registered
// rising-edge pulse for one raw push-button. Rev 1.0
`default_nettype none

module btn_conditioner #(
    parameter int DB_CYCLES = 1_000_000
) (
    input  logic clock,
    input  logic reset_n,
    input  logic raw,
    output logic press
);

    localparam int CNT_W = $clog2(DB_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

    logic             sync_q;
    logic             sync_qq;
    logic             level;
    logic             level_d;
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sync_q  <= 1'b0;
            sync_qq <= 1'b0;
            level   <= 1'b0;
            level_d <= 1'b0;
            cnt     <= '0;
            press   <= 1'b0;
        end else begin
            sync_q  <= raw;
            sync_qq <= sync_q;
            // Level only follows the synchronised input after DB_CYCLES
            // consecutive disagreeing samples; any agreement restarts the run.
            if (sync_qq == level) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                level <= sync_qq;
                cnt   <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
            level_d <= level;
            press   <= level & ~level_d;
        end
    end

endmodule

`default_nettype wire

// File: rtl/timer_ctrl.sv
// timer_ctrl: conditions start/pause/restart buttons and runs the
// run/pause/expire FSM with the 1-per-second tick prescaler. Rev 1.0
`default_nettype none

module timer_ctrl
    import timer_ctrl_pkg::*;
#(
    parameter int TICK_DIV  = 100_000_000,
    parameter int DB_CYCLES = 1_000_000
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             btn_start,
    input  logic             btn_pause,
    input  logic             btn_restart,
    input  logic [SEC_W-1:0] seconds_in,
    input  logic             at_zero,
    output logic             load,
    output logic [SEC_W-1:0] load_value,
    output logic             tick,
    output logic [1:0]       state_o,
    output logic             expired
);

    localparam int PRESC_W = $clog2(TICK_DIV);
    localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(TICK_DIV - 1);

    logic               press_start;
    logic               press_pause;
    logic               press_restart;
    logic               do_start;
    logic               do_pause;
    logic               do_restart;
    state_t             state;
    logic [PRESC_W-1:0] presc;

    btn_conditioner #(.DB_CYCLES(DB_CYCLES)) u_start (
        .clock   (clock),
        .reset_n (reset_n),
        .raw     (btn_start),
        .press   (press_start)
    );

    btn_conditioner #(.DB_CYCLES(DB_CYCLES)) u_pause (
        .clock   (clock),
        .reset_n (reset_n),
        .raw     (btn_pause),
        .press   (press_pause)
    );

    btn_conditioner #(.DB_CYCLES(DB_CYCLES)) u_restart (
        .clock   (clock),
        .reset_n (reset_n),
        .raw     (btn_restart),
        .press   (press_restart)
    );

    assign do_restart = press_restart;
    assign do_pause   = press_pause & ~press_restart;
    assign do_start   = press_start & ~press_pause & ~press_restart;

    assign state_o = state;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state      <= ST_IDLE;
            presc      <= '0;
            load       <= 1'b0;
            load_value <= '0;
            tick       <= 1'b0;
            expired    <= 1'b0;
        end else begin
            load <= 1'b0;
            tick <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    if (do_restart) begin
                        load       <= 1'b1;
                        load_value <= seconds_in;
                    end else if (do_start) begin
                        load       <= 1'b1;
                        load_value <= seconds_in;
                        presc      <= '0;
                        state      <= ST_RUNNING;
                    end
                end
                ST_RUNNING: begin
                    // at_zero is stale during the load cycle; the countdown
                    // stage only reflects the new value one cycle later.
                    if (do_restart) begin
                        load       <= 1'b1;
                        load_value <= seconds_in;
                        state      <= ST_IDLE;
                    end else if (at_zero && !load) begin
                        expired <= 1'b1;
                        state   <= ST_EXPIRED;
                    end else if (do_pause) begin
                        state <= ST_PAUSED;
                    end else if (presc == PRESC_LAST) begin
                        presc <= '0;
                        tick  <= 1'b1;
                    end else begin
                        presc <= presc + 1'b1;
                    end
                end
                ST_PAUSED: begin
                    if (do_restart) begin
                        load       <= 1'b1;
                        load_value <= seconds_in;
                        state      <= ST_IDLE;
                    end else if (do_start) begin
                        state <= ST_RUNNING;
                    end
                end
                ST_EXPIRED: begin
                    if (do_restart) begin
                        load       <= 1'b1;
                        load_value <= seconds_in;
                        expired    <= 1'b0;
                        state      <= ST_IDLE;
                    end
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_timer_ctrl.sv
// tb_timer_ctrl: directed self-checking bench for timer_ctrl with a
// behavioural countdown stage closing the at_zero loop. Rev 1.0
`default_nettype none

module tb_timer_ctrl;

    localparam int TICK_DIV  = 10;
    localparam int DB_CYCLES = 4;

    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic       btn_start = 1'b0;
    logic       btn_pause = 1'b0;
    logic       btn_restart = 1'b0;
    logic [5:0] seconds_in = 6'd0;
    logic       at_zero;
    logic       load;
    logic [5:0] load_value;
    logic       tick;
    logic [1:0] state_o;
    logic       expired;

    logic [5:0] cd_cnt;
    int         tick_cnt = 0;
    int         load_cnt = 0;
    int         checks = 0;
    int         errors = 0;
    int         base;

    timer_ctrl #(.TICK_DIV(TICK_DIV), .DB_CYCLES(DB_CYCLES)) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .btn_start   (btn_start),
        .btn_pause   (btn_pause),
        .btn_restart (btn_restart),
        .seconds_in  (seconds_in),
        .at_zero     (at_zero),
        .load        (load),
        .load_value  (load_value),
        .tick        (tick),
        .state_o     (state_o),
        .expired     (expired)
    );

    always #5 clock = ~clock;

    always @(posedge clock or negedge reset_n) begin
        if (!reset_n)                  cd_cnt <= 6'd0;
        else if (load)                 cd_cnt <= load_value;
        else if (tick && cd_cnt != 0)  cd_cnt <= cd_cnt - 6'd1;
    end
    assign at_zero = (cd_cnt == 6'd0);

    always @(posedge clock) begin
        if (tick) tick_cnt <= tick_cnt + 1;
        if (load) load_cnt <= load_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clock);
        @(negedge clock);
    endtask

    // Raw press long enough to debounce; returns when the FSM response is visible.
    task automatic press(input logic [2:0] m);
        {btn_restart, btn_pause, btn_start} = m;
        step(DB_CYCLES + 4);
        {btn_restart, btn_pause, btn_start} = 3'b000;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clock);
        check("rst_load",    32'(load),       32'd0);
        check("rst_tick",    32'(tick),       32'd0);
        check("rst_state",   32'(state_o),    32'd0);
        check("rst_expired", 32'(expired),    32'd0);
        check("rst_lval",    32'(load_value), 32'd0);
        reset_n = 1'b1;
        step(3);

        // Short glitch, then a real press with 3 s preset
        seconds_in = 6'd3;
        btn_start = 1'b1;
        step(2);
        btn_start = 1'b0;
        step(12);
        check("glitch_no_load",  32'(load_cnt), 32'd0);
        check("glitch_state",    32'(state_o),  32'd0);
        btn_start = 1'b1;
        step(7);
        check("start_early",     32'(load),       32'd0);
        step(1);
        check("start_load",      32'(load),       32'd1);
        check("start_lval",      32'(load_value), 32'd3);
        check("start_state",     32'(state_o),    32'd1);
        step(2);
        btn_start = 1'b0;
        step(7);
        check("tick1_early",     32'(tick),     32'd0);
        step(1);
        check("tick1",           32'(tick),     32'd1);
        step(10);
        check("tick2",           32'(tick),     32'd1);
        step(10);
        check("tick3",           32'(tick),     32'd1);
        step(2);
        check("exp_state",       32'(state_o),  32'd3);
        check("exp_flag",        32'(expired),  32'd1);
        step(20);
        check("exp_no_4th_tick", 32'(tick_cnt), 32'd3);
        press(3'b100);
        check("rst_from_exp_load",  32'(load),    32'd1);
        check("rst_from_exp_state", 32'(state_o), 32'd0);
        check("rst_from_exp_flag",  32'(expired), 32'd0);

        // Pause with prescaler at 6, resume
        seconds_in = 6'd20;
        step(10);
        press(3'b001);
        check("run20_lval", 32'(load_value), 32'd20);
        base = tick_cnt;
        step(9);
        press(3'b010);
        check("pause_state", 32'(state_o),  32'd2);
        check("pause_ticks", 32'(tick_cnt), 32'(base + 1));
        step(50);
        check("paused_hold_state", 32'(state_o),  32'd2);
        check("paused_no_ticks",   32'(tick_cnt), 32'(base + 1));
        press(3'b001);
        check("resume_state", 32'(state_o), 32'd1);
        step(3);
        check("resume_tick_early", 32'(tick), 32'd0);
        step(1);
        check("resume_tick", 32'(tick), 32'd1);

        // All three buttons at once: restart wins
        seconds_in = 6'd11;
        step(10);
        press(3'b111);
        check("all3_load",  32'(load),       32'd1);
        check("all3_state", 32'(state_o),    32'd0);
        check("all3_lval",  32'(load_value), 32'd11);

        // Zero preset expires without ticking
        seconds_in = 6'd0;
        step(10);
        press(3'b001);
        check("zero_load",  32'(load),       32'd1);
        check("zero_lval",  32'(load_value), 32'd0);
        check("zero_state", 32'(state_o),    32'd1);
        base = tick_cnt;
        step(2);
        check("zero_exp_state", 32'(state_o), 32'd3);
        check("zero_exp_flag",  32'(expired), 32'd1);
        step(20);
        check("zero_no_ticks", 32'(tick_cnt), 32'(base));
        base = load_cnt;
        press(3'b001);
        check("exp_ign_start_state", 32'(state_o),  32'd3);
        check("exp_ign_start_load",  32'(load_cnt), 32'(base));
        step(10);
        press(3'b010);
        check("exp_ign_pause_state", 32'(state_o), 32'd3);
        seconds_in = 6'd13;
        step(10);
        press(3'b100);
        check("zero_restart_load",  32'(load),       32'd1);
        check("zero_restart_state", 32'(state_o),    32'd0);
        check("zero_restart_lval",  32'(load_value), 32'd13);
        check("zero_restart_exp",   32'(expired),    32'd0);

        // Preset changes between loads are ignored
        seconds_in = 6'd5;
        step(10);
        press(3'b001);
        check("hold_lval_start", 32'(load_value), 32'd5);
        step(3);
        seconds_in = 6'd9;
        step(15);
        check("hold_lval_run",   32'(load_value), 32'd5);
        check("hold_state_run",  32'(state_o),    32'd1);
        press(3'b100);
        check("hold_lval_reload", 32'(load_value), 32'd9);
        check("hold_state_idle",  32'(state_o),    32'd0);

        // Reset mid-run with start held through release
        step(10);
        press(3'b001);
        step(5);
        base = tick_cnt;
        btn_start = 1'b1;
        reset_n = 1'b0;
        #1;
        check("mid_rst_load",    32'(load),       32'd0);
        check("mid_rst_tick",    32'(tick),       32'd0);
        check("mid_rst_state",   32'(state_o),    32'd0);
        check("mid_rst_expired", 32'(expired),    32'd0);
        check("mid_rst_lval",    32'(load_value), 32'd0);
        @(negedge clock);
        reset_n = 1'b1;
        check("rel_state", 32'(state_o), 32'd0);
        step(7);
        check("rel_no_load", 32'(load),     32'd0);
        check("rel_no_tick", 32'(tick_cnt), 32'(base));
        step(1);
        check("held_load",  32'(load),       32'd1);
        check("held_state", 32'(state_o),    32'd1);
        check("held_lval",  32'(load_value), 32'd9);
        btn_start = 1'b0;
        step(5);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
